// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks the line up in the L1, answers on CR/CD and updates line state.
// Optional feature: define ACE_SNOOP_RESPONDER_ERR_EN to flag unsupported snoop codes with the CR Error bit.

package ace_snoop_responder_pkg;
  localparam int unsigned AcAddrWidth    = 32;
  localparam int unsigned CdDataWidth    = 64;
  localparam int unsigned CacheLineWidth = 256;

  typedef struct packed {
    logic                   ac_valid;
    logic [AcAddrWidth-1:0] ac_addr;
    logic [3:0]             ac_snoop;
    logic                   cr_ready;
    logic                   cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic                   ac_ready;
    logic                   cr_valid;
    logic [4:0]             cr_resp;
    logic                   cd_valid;
    logic [CdDataWidth-1:0] cd_data;
    logic                   cd_last;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned AddrWidth = ace_snoop_responder_pkg::AcAddrWidth,
  parameter int unsigned DataWidth = ace_snoop_responder_pkg::CdDataWidth,
  parameter int unsigned LineWidth = ace_snoop_responder_pkg::CacheLineWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  ace_snoop_responder_pkg::snoop_req_t  snoop_req_i,
  output ace_snoop_responder_pkg::snoop_resp_t snoop_resp_o,
  output logic                                 lookup_req_o,
  output logic [AddrWidth-1:0]                 lookup_addr_o,
  input  logic                                 lookup_gnt_i,
  input  logic                                 lookup_valid_i,
  input  logic                                 lookup_hit_i,
  input  logic                                 lookup_dirty_i,
  input  logic                                 lookup_shared_i,
  input  logic [LineWidth-1:0]                 lookup_data_i,
  output logic                                 upd_valid_o,
  output logic [1:0]                           upd_op_o,
  output logic [AddrWidth-1:0]                 upd_addr_o,
  input  logic                                 upd_ready_i
);

  localparam int unsigned Beats     = LineWidth / DataWidth;
  localparam int unsigned BeatWidth = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned BeatShift = $clog2(DataWidth / 8);
  localparam logic [AddrWidth-1:0] LineMask = AddrWidth'(LineWidth / 8 - 1);
  localparam logic [AddrWidth-1:0] BeatMask = AddrWidth'(Beats - 1);
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(Beats - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} state_e;

  typedef enum logic [1:0] {
    UPD_NONE        = 2'd0,
    UPD_INVALIDATE  = 2'd1,
    UPD_MAKE_SHARED = 2'd2,
    UPD_CLEAN       = 2'd3
  } upd_op_e;

  typedef enum logic [3:0] {
    SNP_READ_ONCE     = 4'b0000,
    SNP_READ_SHARED   = 4'b0001,
    SNP_READ_CLEAN    = 4'b0010,
    SNP_READ_NSD      = 4'b0011,
    SNP_READ_UNIQUE   = 4'b0111,
    SNP_CLEAN_SHARED  = 4'b1000,
    SNP_CLEAN_INVALID = 4'b1001,
    SNP_MAKE_INVALID  = 4'b1101
  } snoop_e;

  state_e                          state_q, state_d;
  logic [AddrWidth-1:0]            addr_q;
  logic [3:0]                      snoop_q;
  logic [Beats-1:0][DataWidth-1:0] line_q;
  logic [4:0]                      resp_q;
  upd_op_e                         op_q;
  logic                            cr_pend_q, cd_pend_q, upd_pend_q;
  logic [BeatWidth-1:0]            beat_idx_q, beat_cnt_q;

  logic [AddrWidth-1:0] line_addr;
  logic [BeatWidth-1:0] start_beat;
  logic                 cr_hs, cd_hs, upd_hs, cd_last, resp_done;
  logic                 dec_dt, dec_pd, dec_is, dec_unsup;
  upd_op_e              dec_op, next_op;
  logic [4:0]           next_resp;

  assign line_addr  = addr_q & ~LineMask;
  assign start_beat = BeatWidth'((addr_q >> BeatShift) & BeatMask);
  assign cd_last    = cd_pend_q && (beat_cnt_q == LastBeat);
  assign cr_hs      = cr_pend_q && snoop_req_i.cr_ready;
  assign cd_hs      = cd_pend_q && snoop_req_i.cd_ready;
  assign upd_hs     = upd_pend_q && upd_ready_i;
  assign resp_done  = (!cr_pend_q || cr_hs) && (!cd_pend_q || (cd_hs && cd_last)) &&
                      (!upd_pend_q || upd_hs);

  // CR response and state update for the stored snoop, from the live lookup result.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_dt    = 1'b0;
    dec_pd    = 1'b0;
    dec_is    = 1'b0;
    dec_unsup = 1'b0;
    dec_op    = UPD_NONE;
    case (snoop_q)
      SNP_READ_ONCE: begin
        dec_dt = 1'b1;
        dec_is = 1'b1;
      end
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
        dec_dt = 1'b1;
        dec_is = 1'b1;
        dec_op = UPD_MAKE_SHARED;
      end
      SNP_READ_UNIQUE: begin
        dec_dt = 1'b1;
        dec_pd = lookup_dirty_i;
        dec_op = UPD_INVALIDATE;
      end
      SNP_CLEAN_SHARED: begin
        dec_dt = lookup_dirty_i;
        dec_pd = lookup_dirty_i;
        dec_is = 1'b1;
        dec_op = lookup_dirty_i ? UPD_CLEAN : UPD_NONE;
      end
      SNP_CLEAN_INVALID: begin
        dec_dt = lookup_dirty_i;
        dec_pd = lookup_dirty_i;
        dec_op = UPD_INVALIDATE;
      end
      SNP_MAKE_INVALID: dec_op = UPD_INVALIDATE;
      default:          dec_unsup = 1'b1;
    endcase

    next_resp = '0;
    next_op   = UPD_NONE;
    if (dec_unsup) begin
`ifdef ACE_SNOOP_RESPONDER_ERR_EN
      next_resp = 5'b00010;
`else
      next_resp = 5'b00000;
`endif
    end else if (lookup_hit_i) begin
      next_resp = {~lookup_shared_i, dec_is, dec_pd, 1'b0, dec_dt};
      next_op   = dec_op;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    lookup_req_o = 1'b0;
    snoop_resp_o = '0;
    case (state_q)
      IDLE:    if (snoop_req_i.ac_valid) state_d = LOOKUP;
      LOOKUP: begin
        lookup_req_o = 1'b1;
        if (lookup_gnt_i) state_d = WAIT;
      end
      WAIT:    if (lookup_valid_i) state_d = RESP;
      RESP:    if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    snoop_resp_o.ac_ready = (state_q == IDLE);
    snoop_resp_o.cr_valid = cr_pend_q;
    snoop_resp_o.cr_resp  = resp_q;
    snoop_resp_o.cd_valid = cd_pend_q;
    snoop_resp_o.cd_data  = line_q[beat_idx_q];
    snoop_resp_o.cd_last  = cd_last;
  end

  // NOTE: the line buffer is a plain register and is cleared on reset so every payload reads 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      snoop_q    <= '0;
      line_q     <= '0;
      resp_q     <= '0;
      op_q       <= UPD_NONE;
      cr_pend_q  <= 1'b0;
      cd_pend_q  <= 1'b0;
      upd_pend_q <= 1'b0;
      beat_idx_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      if (state_q == IDLE && snoop_req_i.ac_valid) begin
        addr_q  <= snoop_req_i.ac_addr;
        snoop_q <= snoop_req_i.ac_snoop;
      end
      if (state_q == WAIT && lookup_valid_i) begin
        line_q     <= lookup_data_i;
        resp_q     <= next_resp;
        op_q       <= next_op;
        cr_pend_q  <= 1'b1;
        cd_pend_q  <= next_resp[0];
        upd_pend_q <= (next_op != UPD_NONE);
        beat_idx_q <= start_beat;
        beat_cnt_q <= '0;
      end
      if (cr_hs) cr_pend_q <= 1'b0;
      // Critical word first: the index wraps at the line end, the count marks the last beat.
      if (cd_hs) begin
        beat_idx_q <= (beat_idx_q == LastBeat) ? '0 : beat_idx_q + 1'b1;
        beat_cnt_q <= beat_cnt_q + 1'b1;
        if (cd_last) cd_pend_q <= 1'b0;
      end
      if (upd_hs) upd_pend_q <= 1'b0;
    end
  end

  assign lookup_addr_o = line_addr;
  assign upd_valid_o   = upd_pend_q;
  assign upd_op_o      = op_q;
  assign upd_addr_o    = line_addr;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Randomized self-checking bench for ace_snoop_responder against a rule-level coherence model.
// Define ACE_SNOOP_RESPONDER_ERR_EN for both bench and design to check the Error-bit build.

module tb_ace_snoop_responder;
  import ace_snoop_responder_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int LW    = 256;
  localparam int BEATS = LW / DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  snoop_req_t    req;
  snoop_resp_t   resp;
  logic          lookup_req;
  logic [AW-1:0] lookup_addr;
  logic          gnt, lvalid, lhit, ldirty, lshared;
  logic [LW-1:0] ldata;
  logic          upd_valid;
  logic [1:0]    upd_op;
  logic [AW-1:0] upd_addr;
  logic          upd_ready;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .snoop_req_i    (req),
    .snoop_resp_o   (resp),
    .lookup_req_o   (lookup_req),
    .lookup_addr_o  (lookup_addr),
    .lookup_gnt_i   (gnt),
    .lookup_valid_i (lvalid),
    .lookup_hit_i   (lhit),
    .lookup_dirty_i (ldirty),
    .lookup_shared_i(lshared),
    .lookup_data_i  (ldata),
    .upd_valid_o    (upd_valid),
    .upd_op_o       (upd_op),
    .upd_addr_o     (upd_addr),
    .upd_ready_i    (upd_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Coherence outcome derived from what each snoop does to the snooped copy of the line.
  function automatic void model(input logic [3:0] snp, input bit hit, dirty, shared,
                                output logic [4:0] cr, output logic [1:0] op);
    bit known, keeps, sends, passes;
    known  = snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};
    keeps  = snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
    sends  = (snp inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) || (dirty && (snp inside {4'd8, 4'd9}));
    passes = dirty && (snp inside {4'd7, 4'd8, 4'd9});
    cr = 5'b00000;
    op = 2'd0;
    if (!known) begin
`ifdef ACE_SNOOP_RESPONDER_ERR_EN
      cr = 5'b00010;
`endif
    end else if (hit) begin
      cr = {~shared, keeps, passes, 1'b0, sends};
      if (snp inside {4'd1, 4'd2, 4'd3}) op = 2'd2;
      else if (!keeps)                   op = 2'd1;
      else if (snp == 4'd8 && dirty)     op = 2'd3;
    end
  endfunction

  task automatic do_snoop(input string name, input logic [3:0] snp, input logic [AW-1:0] addr,
                          input bit hit, dirty, shared, input int gnt_dly, valid_dly,
                          input int cr_stall, upd_stall, input bit cd_stall, spurious,
                          input int abort_beat);
    logic [LW-1:0] line;
    logic [4:0]    exp_cr;
    logic [1:0]    exp_op;
    logic [AW-1:0] line_addr;
    logic [DW-1:0] exp_data;
    bit            cr_pend, cd_pend, upd_pend;
    int            k, start, t, cr_first, i, w;
    for (int b = 0; b < LW / 32; b++) line[b*32 +: 32] = $urandom;
    model(snp, hit, dirty, shared, exp_cr, exp_op);
    line_addr = addr & ~AW'(LW / 8 - 1);
    start     = int'((addr >> 3) & AW'(BEATS - 1));

    w = 0;
    while (resp.ac_ready !== 1'b1 && w < 20) begin step(); w++; end
    vectors++;
    if (resp.ac_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ac_ready_before: got %b want 1", name, resp.ac_ready);
    end
    req.ac_valid = 1'b1;
    req.ac_addr  = addr;
    req.ac_snoop = snp;
    step();
    t = 1;
    req.ac_valid = 1'b0;
    req.ac_addr  = AW'($urandom);
    req.ac_snoop = 4'($urandom);
    if (spurious) begin
      lvalid = 1'b1; lhit = ~hit; ldirty = ~dirty; lshared = ~shared; ldata = ~line;
    end

    for (int g = 0; g <= gnt_dly; g++) begin
      vectors++;
      if ({resp.ac_ready, lookup_req, lookup_addr} !== {1'b0, 1'b1, line_addr}) begin
        miscompares++;
        $display("FAIL %s lookup t=%0d: got rdy=%b req=%b addr=%h want rdy=0 req=1 addr=%h",
                 name, t, resp.ac_ready, lookup_req, lookup_addr, line_addr);
      end
      gnt = (g == gnt_dly);
      step(); t++;
      gnt = 1'b0; lvalid = 1'b0;
    end

    for (int v = 0; v <= valid_dly; v++) begin
      vectors++;
      if ({lookup_req, resp.cr_valid, resp.cd_valid, upd_valid} !== 4'b0000) begin
        miscompares++;
        $display("FAIL %s wait t=%0d: got req/cr/cd/upd=%b%b%b%b want 0000",
                 name, t, lookup_req, resp.cr_valid, resp.cd_valid, upd_valid);
      end
      if (v == valid_dly) begin
        lvalid = 1'b1; lhit = hit; ldirty = dirty; lshared = shared; ldata = line;
      end
      step(); t++;
      lvalid = 1'b0; lhit = 1'($urandom); ldirty = 1'($urandom); lshared = 1'($urandom); ldata = ~line;
    end

    cr_pend  = 1'b1;
    cd_pend  = exp_cr[0];
    upd_pend = (exp_op != 2'd0);
    k = 0; cr_first = -1; i = 0;
    while ((cr_pend || cd_pend || upd_pend) && i < 200) begin
      if (resp.cr_valid === 1'b1 && cr_first < 0) cr_first = t;
      exp_data = line[((start + k) % BEATS) * DW +: DW];
      vectors++;
      if (resp.ac_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s ac_ready_busy t=%0d: got %b want 0", name, t, resp.ac_ready);
      end
      vectors++;
      if (resp.cr_valid !== cr_pend || (cr_pend && resp.cr_resp !== exp_cr)) begin
        miscompares++;
        $display("FAIL %s cr t=%0d: got v=%b resp=%b want v=%b resp=%b",
                 name, t, resp.cr_valid, resp.cr_resp, cr_pend, exp_cr);
      end
      vectors++;
      if (resp.cd_valid !== cd_pend ||
          (cd_pend && {resp.cd_data, resp.cd_last} !== {exp_data, (k == BEATS - 1)})) begin
        miscompares++;
        $display("FAIL %s cd beat %0d t=%0d: got v=%b d=%h last=%b want v=%b d=%h last=%b",
                 name, k, t, resp.cd_valid, resp.cd_data, resp.cd_last, cd_pend, exp_data,
                 (k == BEATS - 1));
      end
      vectors++;
      if (upd_valid !== upd_pend || (upd_pend && {upd_op, upd_addr} !== {exp_op, line_addr})) begin
        miscompares++;
        $display("FAIL %s upd t=%0d: got v=%b op=%0d a=%h want v=%b op=%0d a=%h",
                 name, t, upd_valid, upd_op, upd_addr, upd_pend, exp_op, line_addr);
      end
      if (cd_pend && k == abort_beat) begin
        req.cr_ready = 1'b0; req.cd_ready = 1'b0; upd_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        return;
      end
      req.cr_ready = (i >= cr_stall);
      req.cd_ready = cd_stall ? 1'($urandom) : 1'b1;
      upd_ready    = (i >= upd_stall);
      if (cr_pend && req.cr_ready) cr_pend = 1'b0;
      if (cd_pend && req.cd_ready) begin
        k++;
        if (k == BEATS) cd_pend = 1'b0;
      end
      if (upd_pend && upd_ready) upd_pend = 1'b0;
      step(); t++; i++;
    end
    req.cr_ready = 1'b0; req.cd_ready = 1'b0; upd_ready = 1'b0;

    vectors++;
    if (i >= 200) begin
      miscompares++;
      $display("FAIL %s resp_timeout: got %0d cycles want < 200", name, i);
    end
    vectors++;
    if ({resp.ac_ready, resp.cr_valid, resp.cd_valid, upd_valid, lookup_req} !== 5'b10000) begin
      miscompares++;
      $display("FAIL %s back_to_idle: got rdy/cr/cd/upd/req=%b%b%b%b%b want 10000", name,
               resp.ac_ready, resp.cr_valid, resp.cd_valid, upd_valid, lookup_req);
    end
    vectors++;
    if (cr_first != 3 + gnt_dly + valid_dly) begin
      miscompares++;
      $display("FAIL %s cr_latency: got cycle %0d want %0d", name, cr_first, 3 + gnt_dly + valid_dly);
    end
  endtask

  task automatic test_reset();
    snoop_resp_t want;
    want = '0;
    want.ac_ready = 1'b1;
    rst = 1'b1;
    req.ac_valid = 1'b1; req.ac_addr = 32'h0000_1230; req.ac_snoop = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if ({resp, lookup_req, lookup_addr, upd_valid, upd_op, upd_addr} !==
          {want, 1'b0, AW'(0), 1'b0, 2'b00, AW'(0)}) begin
        miscompares++;
        $display("FAIL reset_values cycle %0d: got resp=%h req=%b upd=%b op=%0d want resp=%h, rest 0",
                 c, resp, lookup_req, upd_valid, upd_op, want);
      end
    end
    rst = 1'b0;
    req.ac_valid = 1'b0;
    step();
    vectors++;
    if ({resp.ac_ready, lookup_req} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_no_accept: got rdy=%b req=%b want rdy=1 req=0", resp.ac_ready, lookup_req);
    end
  endtask

  task automatic test_read_shared();
    do_snoop("read_shared", 4'b0001, {AW'($urandom) & ~AW'(31)} | AW'(16), 1, 0, 0,
             0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_clean_invalid_stall();
    do_snoop("clean_invalid_stall", 4'b1001, AW'($urandom), 1, 1, 1, 1, 1, 5, 2, 1, 1, -1);
  endtask

  task automatic test_make_invalid_miss();
    do_snoop("make_invalid_miss", 4'b1101, AW'($urandom), 0, 1, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_unsupported();
    do_snoop("unsupported_hit", 4'b1111, AW'($urandom), 1, 1, 0, 0, 0, 1, 0, 0, 0, -1);
    do_snoop("unsupported_miss", 4'b1111, AW'($urandom), 0, 0, 1, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_reset_mid_cd();
    snoop_resp_t want;
    want = '0;
    want.ac_ready = 1'b1;
    do_snoop("rst_mid_cd", 4'b0001, AW'($urandom), 1, 0, 0, 0, 0, 50, 50, 0, 0, 1);
    vectors++;
    if ({resp, lookup_req, lookup_addr, upd_valid, upd_op, upd_addr} !==
        {want, 1'b0, AW'(0), 1'b0, 2'b00, AW'(0)}) begin
      miscompares++;
      $display("FAIL rst_mid_cd_values: got resp=%h req=%b upd=%b op=%0d want resp=%h, rest 0",
               resp, lookup_req, upd_valid, upd_op, want);
    end
    do_snoop("read_once_after_rst", 4'b0000, AW'($urandom), 1, 1'($urandom), 0,
             0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      do_snoop("random", 4'($urandom_range(0, 15)), AW'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), -1);
    end
  endtask

  initial begin
    req = '0;
    gnt = 1'b0; lvalid = 1'b0; lhit = 1'b0; ldirty = 1'b0; lshared = 1'b0;
    ldata = '0; upd_ready = 1'b0;
    test_reset();
    test_read_shared();
    test_clean_invalid_stall();
    test_make_invalid_miss();
    test_unsupported();
    test_reset_mid_cd();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
